debounce_filter: RTL and testbench
==================================

Name: debounce_filter

Overview:
- Conditions one raw push-button or switch input into a clean, synchronised, active-high level.
- Sits directly upstream of the one-shot press-to-pulse state machine; C_Button_Out drives that block's C_Count_In.
- Structure: two-flop synchroniser, polarity normalisation, then a four-state FSM with a stability counter that only accepts a level change after it has held for STABLE_COUNT consecutive clocks.

Parameters:
- STABLE_COUNT, 1000000, consecutive synchronised samples needed to accept a level change (20 ms at 50 MHz); legal range STABLE_COUNT >= 2.
- CNT_WIDTH, 20, counter width; must satisfy 2^CNT_WIDTH > STABLE_COUNT-1.
- INPUT_ACTIVE_LOW, 1, 1 means a pressed button drives C_Button_In = 0 (board keys); 0 means pressed = 1.

Ports:
- C_CLOCK_50  input  1  system clock, 50 MHz, rising edge.
- C_Reset_n  input  1  reset, asynchronous, active-low.
- C_Button_In  input  1  raw, asynchronous, bouncing button or switch.
- C_Button_Out  output  1  debounced level, 1 = pressed, synchronous to C_CLOCK_50.
- C_Busy  output  1  1 while a candidate level change is being qualified.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (C_Reset_n = 0), asynchronous, applied immediately:
  - Sync flops load the raw released level: 1 if INPUT_ACTIVE_LOW, else 0.
  - State = ST_STABLE_LOW; counter = 0.
  - C_Button_Out = 0; C_Busy = 0.
- Reset deassertion is only sampled at a clock edge. Reset asserted mid-qualification abandons it with no output change.
- Synchroniser: ff1 <= C_Button_In; ff2 <= ff1.
  - s = ff2 XOR INPUT_ACTIVE_LOW, so s = 1 means pressed.
  - Only s reaches the FSM.
- FSM, registered state with next-state evaluated every clock:
  - ST_STABLE_LOW: if s = 1, go to ST_CHECK_HIGH with cnt <= 1; else stay, cnt <= 0.
  - ST_CHECK_HIGH:
    - If s = 0, go to ST_STABLE_LOW with cnt <= 0 (bounce rejected).
    - Else if cnt = STABLE_COUNT-1, go to ST_STABLE_HIGH with cnt <= 0.
    - Else stay, cnt <= cnt+1.
  - ST_STABLE_HIGH: if s = 0, go to ST_CHECK_LOW with cnt <= 1; else stay, cnt <= 0.
  - ST_CHECK_LOW:
    - If s = 1, go to ST_STABLE_HIGH with cnt <= 0.
    - Else if cnt = STABLE_COUNT-1, go to ST_STABLE_LOW with cnt <= 0.
    - Else stay, cnt <= cnt+1.
  - Any unused encoding goes to ST_STABLE_LOW with cnt <= 0.
- Outputs, decoded from state only (no glitch path from s):
  - C_Button_Out = 1 in ST_STABLE_HIGH and ST_CHECK_LOW; 0 otherwise.
  - C_Busy = 1 in both CHECK states.
- Latency:
  - Let edge k be the first edge at which ff1 captures the new raw level, held steadily from then on.
  - C_Button_Out changes after edge k+1+STABLE_COUNT.
- Glitch rejection: any interruption of s during a CHECK state returns the FSM to the prior stable state. The count restarts from 1 on the next opposite sample; no partial credit is retained.
- Counter: it never exceeds STABLE_COUNT-1 and never wraps. Compare with equality on CNT_WIDTH bits.
- Output is level-only. Edge or pulse generation is the downstream block's job.

Test Plan (STABLE_COUNT = 4, CNT_WIDTH = 3, INPUT_ACTIVE_LOW = 1):
- Reset release with C_Button_In = 1 held:
  - Required: C_Button_Out = 0 and C_Busy = 0 for 20 cycles.
  - Required: asserting C_Reset_n = 0 between edges forces outputs to 0 immediately.
- Clean press, C_Button_In 1->0 captured at edge k:
  - Required: C_Busy = 1 after edge k+2.
  - Required: C_Button_Out = 1 after edge k+5, and C_Busy = 0 at the same time.
- Bouncing press, C_Button_In = 0,1,0,1 for 2 cycles each, then 0 steady:
  - Required: C_Button_Out stays 0 during the bounces.
  - Required: C_Button_Out rises exactly 5 edges after the final steady 0 is captured.
- Glitch rejection:
  - Stimulus: while stable pressed, a 3-cycle release pulse (C_Button_In = 1).
  - Required: C_Button_Out stays 1, C_Busy pulses 1, and the FSM returns to ST_STABLE_HIGH.
- Clean release, C_Button_In 0->1 held:
  - Required: C_Button_Out = 0 after edge k+5.
  - Required: a 4-cycle release pulse is accepted as a release.
- Reset mid-qualification:
  - Stimulus: assert C_Reset_n = 0 in ST_CHECK_HIGH with cnt = 2.
  - Required: outputs 0 and cnt 0.
  - Required: after release with the button held, the full 4-sample qualification is required again.

Source files
------------

// File: rtl/debounce_filter_if.sv
// Button-side signal bundle for debounce_filter: raw input in, debounced level and busy flag out.
interface debounce_filter_if;
   logic C_Button_In;
   logic C_Button_Out;
   logic C_Busy;

   modport master (
      output C_Button_In,
      input  C_Button_Out,
      input  C_Busy
   );

   modport slave (
      input  C_Button_In,
      output C_Button_Out,
      output C_Busy
   );
endinterface

// File: rtl/debounce_filter.sv
// Push-button conditioner: two-flop synchroniser, polarity normalisation and a stability-qualified
// four-state FSM producing a clean active-high level for the downstream press-to-pulse block.
//
// state          | meaning
// ST_STABLE_LOW  | released level accepted, waiting for a pressed sample
// ST_CHECK_HIGH  | pressed samples being counted, output still released
// ST_STABLE_HIGH | pressed level accepted, waiting for a released sample
// ST_CHECK_LOW   | released samples being counted, output still pressed
module debounce_filter #(
   parameter int STABLE_COUNT     = 1000000,
   parameter int CNT_WIDTH        = 20,
   parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
   input  logic         C_CLOCK_50,
   input  logic         C_Reset_n,
   debounce_filter_if.slave btn
);

   typedef enum logic [1:0] {
      ST_STABLE_LOW  = 2'b00,
      ST_CHECK_HIGH  = 2'b01,
      ST_STABLE_HIGH = 2'b10,
      ST_CHECK_LOW   = 2'b11
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

   logic                 sync_ff1;
   logic                 sync_ff2;
   logic                 s;
   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 cnt_done;

   // Sync flops reset to the raw released level so no phantom press follows reset.
   always_ff @(posedge C_CLOCK_50 or negedge C_Reset_n) begin
      if (!C_Reset_n) begin
         sync_ff1 <= INPUT_ACTIVE_LOW;
         sync_ff2 <= INPUT_ACTIVE_LOW;
      end else begin
         sync_ff1 <= btn.C_Button_In;
         sync_ff2 <= sync_ff1;
      end
   end

   assign s        = sync_ff2 ^ INPUT_ACTIVE_LOW;
   assign cnt_done = (cnt == CNT_LAST);

   always_ff @(posedge C_CLOCK_50 or negedge C_Reset_n) begin
      if (!C_Reset_n) begin
         state <= ST_STABLE_LOW;
         cnt   <= CNT_ZERO;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_STABLE_LOW;
      cnt_nxt   = CNT_ZERO;
      case (state)
         ST_STABLE_LOW: begin
            if (s) begin
               state_nxt = ST_CHECK_HIGH;
               cnt_nxt   = CNT_ONE;
            end else begin
               state_nxt = ST_STABLE_LOW;
            end
         end
         ST_CHECK_HIGH: begin
            if (!s) begin
               state_nxt = ST_STABLE_LOW;
            end else if (cnt_done) begin
               state_nxt = ST_STABLE_HIGH;
            end else begin
               state_nxt = ST_CHECK_HIGH;
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         ST_STABLE_HIGH: begin
            if (!s) begin
               state_nxt = ST_CHECK_LOW;
               cnt_nxt   = CNT_ONE;
            end else begin
               state_nxt = ST_STABLE_HIGH;
            end
         end
         ST_CHECK_LOW: begin
            if (s) begin
               state_nxt = ST_STABLE_HIGH;
            end else if (cnt_done) begin
               state_nxt = ST_STABLE_LOW;
            end else begin
               state_nxt = ST_CHECK_LOW;
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = ST_STABLE_LOW;
            cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // Outputs depend on registered state only, so bounces on s never reach them directly.
   always_comb begin
      btn.C_Button_Out = 1'b0;
      btn.C_Busy       = 1'b0;
      case (state)
         ST_CHECK_HIGH:  btn.C_Busy = 1'b1;
         ST_STABLE_HIGH: btn.C_Button_Out = 1'b1;
         ST_CHECK_LOW: begin
            btn.C_Button_Out = 1'b1;
            btn.C_Busy       = 1'b1;
         end
         default: begin
            btn.C_Button_Out = 1'b0;
            btn.C_Busy       = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter with STABLE_COUNT=4, CNT_WIDTH=3, active-low input.
module tb_debounce_filter;
   logic C_CLOCK_50 = 1'b0;
   logic C_Reset_n;
   int   total = 0;
   int   bad   = 0;

   localparam logic [1:0] S_LOW  = 2'b00;
   localparam logic [1:0] S_CHKH = 2'b01;
   localparam logic [1:0] S_HIGH = 2'b10;

   debounce_filter_if bif ();

   debounce_filter #(
      .STABLE_COUNT     (4),
      .CNT_WIDTH        (3),
      .INPUT_ACTIVE_LOW (1'b1)
   ) dut (
      .C_CLOCK_50 (C_CLOCK_50),
      .C_Reset_n  (C_Reset_n),
      .btn        (bif.slave)
   );

   always #5 C_CLOCK_50 = ~C_CLOCK_50;

   task automatic step();
      @(posedge C_CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] bounce;
      bounce = 8'b0011_0011;

      C_Reset_n       = 1'b0;
      bif.C_Button_In = 1'b1;
      #1;
      chk("rst_out", bif.C_Button_Out, 1'b0);
      chk("rst_busy", bif.C_Busy, 1'b0);
      repeat (3) step();
      C_Reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_out", bif.C_Button_Out, 1'b0);
         chk("idle_busy", bif.C_Busy, 1'b0);
      end

      // clean press: edge k captures the 0
      bif.C_Button_In = 1'b0;
      step(); chk("press_k_busy", bif.C_Busy, 1'b0);
      step(); chk("press_k1_busy", bif.C_Busy, 1'b0);
      step(); chk("press_k2_busy", bif.C_Busy, 1'b1);
              chk("press_k2_out", bif.C_Button_Out, 1'b0);
      step();
      step(); chk("press_k4_out", bif.C_Button_Out, 1'b0);
              chk_cnt("press_k4_cnt", dut.cnt, 3'd3);
      step(); chk("press_k5_out", bif.C_Button_Out, 1'b1);
              chk("press_k5_busy", bif.C_Busy, 1'b0);
              chk_st("press_k5_state", dut.state, S_HIGH);
      repeat (3) step();

      // asynchronous reset between edges
      C_Reset_n = 1'b0;
      #2;
      chk("async_rst_out", bif.C_Button_Out, 1'b0);
      chk("async_rst_busy", bif.C_Busy, 1'b0);
      chk_st("async_rst_state", dut.state, S_LOW);
      bif.C_Button_In = 1'b1;
      #1 C_Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_out", bif.C_Button_Out, 1'b0);
      end

      // bouncing press: pairs of 0,1,0,1 then steady 0
      for (int i = 7; i >= 0; i--) begin
         bif.C_Button_In = bounce[i];
         step();
         chk("bounce_out", bif.C_Button_Out, 1'b0);
      end
      bif.C_Button_In = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bounce_settle_out", bif.C_Button_Out, 1'b0);
      end
      step(); chk("bounce_k5_out", bif.C_Button_Out, 1'b1);
      repeat (3) step();

      // 3-cycle release glitch while pressed
      bif.C_Button_In = 1'b1;
      step(); chk("glitch_k_out", bif.C_Button_Out, 1'b1);  chk("glitch_k_busy", bif.C_Busy, 1'b0);
      step(); chk("glitch_k1_out", bif.C_Button_Out, 1'b1); chk("glitch_k1_busy", bif.C_Busy, 1'b0);
      step(); chk("glitch_k2_out", bif.C_Button_Out, 1'b1); chk("glitch_k2_busy", bif.C_Busy, 1'b1);
      bif.C_Button_In = 1'b0;
      step(); chk("glitch_k3_out", bif.C_Button_Out, 1'b1); chk("glitch_k3_busy", bif.C_Busy, 1'b1);
      step(); chk("glitch_k4_out", bif.C_Button_Out, 1'b1); chk("glitch_k4_busy", bif.C_Busy, 1'b1);
              chk_cnt("glitch_k4_cnt", dut.cnt, 3'd3);
      step(); chk("glitch_k5_out", bif.C_Button_Out, 1'b1); chk("glitch_k5_busy", bif.C_Busy, 1'b0);
              chk_st("glitch_k5_state", dut.state, S_HIGH);
      step(); chk_st("glitch_k6_state", dut.state, S_HIGH);

      // clean release held
      bif.C_Button_In = 1'b1;
      repeat (5) step();
      chk("release_k4_out", bif.C_Button_Out, 1'b1);
      step(); chk("release_k5_out", bif.C_Button_Out, 1'b0);
              chk("release_k5_busy", bif.C_Busy, 1'b0);
              chk_st("release_k5_state", dut.state, S_LOW);

      // re-press, then a 4-cycle release pulse is accepted
      bif.C_Button_In = 1'b0;
      repeat (6) step();
      chk("repress_out", bif.C_Button_Out, 1'b1);
      bif.C_Button_In = 1'b1;
      repeat (4) step();
      bif.C_Button_In = 1'b0;
      step(); chk("pulse4_k4_out", bif.C_Button_Out, 1'b1); chk("pulse4_k4_busy", bif.C_Busy, 1'b1);
      step(); chk("pulse4_k5_out", bif.C_Button_Out, 1'b0);
              chk_st("pulse4_k5_state", dut.state, S_LOW);
      step(); chk_st("pulse4_k6_state", dut.state, S_CHKH);
      repeat (3) step();
      chk("pulse4_k9_out", bif.C_Button_Out, 1'b1);
      bif.C_Button_In = 1'b1;
      repeat (6) step();
      chk("pulse4_release_out", bif.C_Button_Out, 1'b0);
      chk_st("pulse4_release_state", dut.state, S_LOW);

      // reset in ST_CHECK_HIGH with cnt = 2
      bif.C_Button_In = 1'b0;
      repeat (4) step();
      chk_st("midq_pre_state", dut.state, S_CHKH);
      chk_cnt("midq_pre_cnt", dut.cnt, 3'd2);
      C_Reset_n = 1'b0;
      #2;
      chk("midq_rst_out", bif.C_Button_Out, 1'b0);
      chk("midq_rst_busy", bif.C_Busy, 1'b0);
      chk_cnt("midq_rst_cnt", dut.cnt, 3'd0);
      chk_st("midq_rst_state", dut.state, S_LOW);
      #1 C_Reset_n = 1'b1;
      step(); chk("midq_k_busy", bif.C_Busy, 1'b0);
      step(); chk("midq_k1_busy", bif.C_Busy, 1'b0);
      step(); chk("midq_k2_busy", bif.C_Busy, 1'b1);
              chk_cnt("midq_k2_cnt", dut.cnt, 3'd1);
      step();
      step(); chk("midq_k4_out", bif.C_Button_Out, 1'b0);
      step(); chk("midq_k5_out", bif.C_Button_Out, 1'b1);
              chk("midq_k5_busy", bif.C_Busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
